wb_bus_arbiter: RTL and testbench
=================================

Name: wb_bus_arbiter

Overview:
- Two-master / two-slave Wishbone interconnect for the frequency-counter SoC.
- Replaces the ad-hoc OR-ing of slave outputs. Lets a second master (measurement sequencer / DMA) share the bus with control_unit.
- Master side: round-robin arbitration with LOCK support. Slave side: address decode, qualified per-slave CYC/STB, response muxing. Also returns a bus-timeout ERR for hung or unmapped accesses.

Parameters:
- UART_BASE, 32'h0000_0000: UART slave base address.
- UART_MASK, 32'hFFFF_FF00: UART decode mask.
- CNT_BASE, 32'h0000_0100: frequency_counter slave base address.
- CNT_MASK, 32'hFFFF_FF00: frequency_counter decode mask.
- TIMEOUT, 8'd255: cycles STB may wait without ACK/ERR/RTY before forced ERR.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous, active-low reset.
- m_cyc_i, m_stb_i, m_we_i, m_lock_i  in  2 each  per-master strobes. Bit 0 = control_unit, bit 1 = second master.
- m_addr_i  in  64  {m1,m0} addresses.
- m_dat_i  in  64  {m1,m0} write data.
- m_sel_i  in  8  {m1,m0} byte selects.
- m_dat_o  out  32  read data, broadcast to both masters.
- m_ack_o, m_err_o, m_rty_o  out  2 each  per-master responses.
- s_addr_o  out  32  shared slave address.
- s_dat_o  out  32  shared slave write data.
- s_sel_o  out  4  shared slave byte selects.
- s_we_o, s_lock_o  out  1 each  shared slave strobes.
- s_cyc_o, s_stb_o  out  2 each  per-slave qualified strobes. Bit 0 = UART, bit 1 = counter.
- s_dat_i  in  64  {counter,uart} read data.
- s_ack_i, s_err_i, s_rty_i  in  2 each  per-slave responses.
- grant_o  out  2  one-hot current owner, for debug and LED.

Behaviour:
- Reset: the following are all 0 while rst_i is low:
  - outputs: grant_o, s_cyc_o, s_stb_o, s_we_o, s_lock_o, m_ack_o, m_err_o, m_rty_o, m_dat_o, s_addr_o, s_dat_o, s_sel_o;
  - registers: last_grant (=0, so m1 wins the first tie), timeout counter;
  - FSM state (IDLE).
  Release takes effect on the next clk_i edge.
- FSM states: IDLE, OWN0, OWN1.
  - IDLE: if only one m_cyc_i is high, go to that OWNx.
  - IDLE, both high: go to the master != last_grant. last_grant updates on entry to OWNx.
  - OWNx: stay while m_cyc_i[x]=1 OR m_lock_i[x]=1.
  - OWNx: when m_cyc_i[x]=0 and m_lock_i[x]=0, return to IDLE. This gives one idle cycle minimum between owners.
  - Cycle latency: request at edge n, grant_o valid after edge n+1, slave strobes may assert in cycle n+1.
- Shared path: shared slave outputs are a combinational mux of the owner's signals. All zero in IDLE.
- Decode, per slave k: hit_k = ((addr & MASK_k) == BASE_k).
  - s_cyc_o[k] = owner cyc & hit_k.
  - s_stb_o[k] = owner stb & hit_k & ~timed_out.
  - Both hits true: UART wins.
- Response path:
  - m_ack_o/m_rty_o[x] = OR of hit-slave ack/rty, gated by grant_o[x].
  - m_dat_o = hit slave's s_dat_i; 0 if no hit.
  - The non-owner always sees ack/err/rty = 0.
- Unmapped address: owner stb high and no hit → m_err_o[x]=1 in the following cycle, for exactly 1 cycle per strobe.
- Timeout: 8-bit counter.
  - Clears when stb is low or any response is seen.
  - Increments each cycle the owner stb is high with no response.
  - On reaching TIMEOUT: assert m_err_o[x] for 1 cycle, set timed_out (suppresses s_stb_o), clear counter.
  - timed_out clears when owner stb drops.
- Simultaneous slave ERR and ACK: ERR takes precedence; ACK is masked.
- Owner drops cyc mid-transfer: strobes to the slave deassert combinationally in the same cycle. Any late slave ACK is discarded.
- Async reset mid-transfer: all strobes drop immediately, with no response to the master.

Decomposition:
- Shared package wb_defs_pkg holds:
  - address map constants (UART_BASE/MASK, CNT_BASE/MASK);
  - FSM state encoding (IDLE=2'd0, OWN0=2'd1, OWN1=2'd2);
  - master/slave index constants.
- One sub-module: wb_addr_decoder. Combinational address → one-hot hit plus no_hit flag. Reused by the future top-level register map.

Test Plan:
- Single master: m0 cyc/stb, read 0x104, counter s_ack_i=1 with s_dat_i=0xDEADBEEF → m_ack_o[0]=1, m_dat_o=0xDEADBEEF, s_stb_o=2'b10, grant_o=2'b01.
- Contention: both masters assert cyc on the same edge after reset → m1 granted first. After m1 drops cyc, one IDLE cycle, then m0 granted. Alternation repeats over 4 requests.
- Lock: m0 asserts lock, drops cyc for 3 cycles while m1 is requesting → grant_o stays 2'b01 until lock deasserts.
- Unmapped: m1 writes 0x0000_0400 → no s_stb_o asserted; m_err_o[1]=1 for exactly 1 cycle.
- Timeout: UART never acks → m_err_o[0] pulses at cycle 255 after stb. s_stb_o[0] is low afterwards until m0 stb drops.
- Reset mid-cycle: pull rst_i low during a granted write → all outputs 0 asynchronously. After release, the FSM is IDLE and last_grant=0.

Source files
------------

// File: rtl/wb_defs_pkg.sv
// Shared Wishbone definitions for the frequency-counter SoC interconnect:
// address map, arbiter state encoding and master/slave indices.
package wb_defs_pkg;

  localparam logic [31:0] UART_BASE_DEF = 32'h0000_0000;
  localparam logic [31:0] UART_MASK_DEF = 32'hFFFF_FF00;
  localparam logic [31:0] CNT_BASE_DEF  = 32'h0000_0100;
  localparam logic [31:0] CNT_MASK_DEF  = 32'hFFFF_FF00;
  localparam logic [7:0]  TIMEOUT_DEF   = 8'd255;

  localparam int M0     = 0;
  localparam int M1     = 1;
  localparam int S_UART = 0;
  localparam int S_CNT  = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

endpackage

// File: rtl/wb_addr_decoder.sv
// Combinational address decoder: one-hot slave hit (UART has priority on
// overlapping windows) plus a flag for unmapped addresses.
module wb_addr_decoder
  import wb_defs_pkg::*;
#(
  parameter logic [31:0] UART_BASE = UART_BASE_DEF,
  parameter logic [31:0] UART_MASK = UART_MASK_DEF,
  parameter logic [31:0] CNT_BASE  = CNT_BASE_DEF,
  parameter logic [31:0] CNT_MASK  = CNT_MASK_DEF
) (
  input  logic [31:0] addr,
  output logic [1:0]  hit,
  output logic        no_hit
);

  logic uart_hit;
  logic cnt_hit;

  always_comb begin
    uart_hit    = ((addr & UART_MASK) == UART_BASE);
    cnt_hit     = ((addr & CNT_MASK) == CNT_BASE);
    hit         = '0;
    hit[S_UART] = uart_hit;
    hit[S_CNT]  = cnt_hit & ~uart_hit;
    no_hit      = ~(uart_hit | cnt_hit);
  end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Two-master / two-slave Wishbone interconnect: round-robin arbitration with
// LOCK, address decode, response muxing and bus-timeout ERR generation.
module wb_bus_arbiter
  import wb_defs_pkg::*;
#(
  parameter logic [31:0] UART_BASE = UART_BASE_DEF,
  parameter logic [31:0] UART_MASK = UART_MASK_DEF,
  parameter logic [31:0] CNT_BASE  = CNT_BASE_DEF,
  parameter logic [31:0] CNT_MASK  = CNT_MASK_DEF,
  parameter logic [7:0]  TIMEOUT   = TIMEOUT_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  m_cyc_i,
  input  logic [1:0]  m_stb_i,
  input  logic [1:0]  m_we_i,
  input  logic [1:0]  m_lock_i,
  input  logic [63:0] m_addr_i,
  input  logic [63:0] m_dat_i,
  input  logic [7:0]  m_sel_i,
  output logic [31:0] m_dat_o,
  output logic [1:0]  m_ack_o,
  output logic [1:0]  m_err_o,
  output logic [1:0]  m_rty_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  output logic        s_we_o,
  output logic        s_lock_o,
  output logic [1:0]  s_cyc_o,
  output logic [1:0]  s_stb_o,
  input  logic [63:0] s_dat_i,
  input  logic [1:0]  s_ack_i,
  input  logic [1:0]  s_err_i,
  input  logic [1:0]  s_rty_i,
  output logic [1:0]  grant_o
);

  state_t      state_q, state_d;
  logic        last_grant_q;
  logic [7:0]  tmo_cnt_q;
  logic        done_q;
  logic [1:0]  err_q;

  logic        own_cyc, own_stb;
  logic [1:0]  dec_hit, hit;
  logic        no_hit;
  logic        stb_act, resp_any, slv_err;
  logic        unmapped, tmo_fire, cnt_en;

  // State register; last_grant follows each entry into an OWN state
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && state_d == OWN0) last_grant_q <= 1'b0;
      else if (state_q == IDLE && state_d == OWN1) last_grant_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (m_cyc_i[M0] && m_cyc_i[M1]) state_d = last_grant_q ? OWN0 : OWN1;
        else if (m_cyc_i[M0])           state_d = OWN0;
        else if (m_cyc_i[M1])           state_d = OWN1;
      end
      OWN0: if (!m_cyc_i[M0] && !m_lock_i[M0]) state_d = IDLE;
      OWN1: if (!m_cyc_i[M1] && !m_lock_i[M1]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Owner mux: everything on the shared slave side is zero while IDLE
  always_comb begin
    grant_o  = '0;
    own_cyc  = 1'b0;
    own_stb  = 1'b0;
    s_we_o   = 1'b0;
    s_lock_o = 1'b0;
    s_addr_o = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    unique case (state_q)
      OWN0: begin
        grant_o[M0] = 1'b1;
        own_cyc     = m_cyc_i[M0];
        own_stb     = m_stb_i[M0];
        s_we_o      = m_we_i[M0];
        s_lock_o    = m_lock_i[M0];
        s_addr_o    = m_addr_i[31:0];
        s_dat_o     = m_dat_i[31:0];
        s_sel_o     = m_sel_i[3:0];
      end
      OWN1: begin
        grant_o[M1] = 1'b1;
        own_cyc     = m_cyc_i[M1];
        own_stb     = m_stb_i[M1];
        s_we_o      = m_we_i[M1];
        s_lock_o    = m_lock_i[M1];
        s_addr_o    = m_addr_i[63:32];
        s_dat_o     = m_dat_i[63:32];
        s_sel_o     = m_sel_i[7:4];
      end
      default: ;
    endcase
  end

  wb_addr_decoder #(
    .UART_BASE (UART_BASE),
    .UART_MASK (UART_MASK),
    .CNT_BASE  (CNT_BASE),
    .CNT_MASK  (CNT_MASK)
  ) u_dec (
    .addr   (s_addr_o),
    .hit    (dec_hit),
    .no_hit (no_hit)
  );

  // Hits are qualified by owner CYC so a late slave response after CYC drops is ignored
  always_comb begin
    hit      = dec_hit & {2{own_cyc}};
    stb_act  = own_cyc & own_stb;
    s_cyc_o  = hit;
    s_stb_o  = hit & {2{stb_act & ~done_q}};
    slv_err  = |(s_err_i & hit);
    resp_any = |((s_ack_i | s_err_i | s_rty_i) & hit);
    unmapped = stb_act & no_hit & ~done_q;
    cnt_en   = stb_act & ~no_hit & ~done_q & ~resp_any;
    tmo_fire = cnt_en & ((tmo_cnt_q + 8'd1) == TIMEOUT);
    m_ack_o  = grant_o & {2{|(s_ack_i & hit) & ~slv_err}};
    m_rty_o  = grant_o & {2{|(s_rty_i & hit)}};
    m_err_o  = err_q | (grant_o & {2{slv_err}});
    m_dat_o  = '0;
    if (hit[S_UART])     m_dat_o = s_dat_i[31:0];
    else if (hit[S_CNT]) m_dat_o = s_dat_i[63:32];
  end

  // done_q holds off the strobe and further ERRs until the owner drops STB
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      tmo_cnt_q <= '0;
      done_q    <= 1'b0;
      err_q     <= '0;
    end else begin
      err_q <= grant_o & {2{unmapped | tmo_fire}};
      if (!cnt_en || tmo_fire) tmo_cnt_q <= '0;
      else                     tmo_cnt_q <= tmo_cnt_q + 8'd1;
      if (!stb_act)                  done_q <= 1'b0;
      else if (unmapped || tmo_fire) done_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed self-checking bench for wb_bus_arbiter with hand-computed expectations.
module tb_wb_bus_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [1:0]  m_cyc_i, m_stb_i, m_we_i, m_lock_i;
  logic [63:0] m_addr_i, m_dat_i;
  logic [7:0]  m_sel_i;
  logic [31:0] m_dat_o;
  logic [1:0]  m_ack_o, m_err_o, m_rty_o;
  logic [31:0] s_addr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic        s_we_o, s_lock_o;
  logic [1:0]  s_cyc_o, s_stb_o;
  logic [63:0] s_dat_i;
  logic [1:0]  s_ack_i, s_err_i, s_rty_i;
  logic [1:0]  grant_o;

  int n_checks = 0;
  int n_pass   = 0;

  wb_bus_arbiter dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .m_cyc_i  (m_cyc_i),
    .m_stb_i  (m_stb_i),
    .m_we_i   (m_we_i),
    .m_lock_i (m_lock_i),
    .m_addr_i (m_addr_i),
    .m_dat_i  (m_dat_i),
    .m_sel_i  (m_sel_i),
    .m_dat_o  (m_dat_o),
    .m_ack_o  (m_ack_o),
    .m_err_o  (m_err_o),
    .m_rty_o  (m_rty_o),
    .s_addr_o (s_addr_o),
    .s_dat_o  (s_dat_o),
    .s_sel_o  (s_sel_o),
    .s_we_o   (s_we_o),
    .s_lock_o (s_lock_o),
    .s_cyc_o  (s_cyc_o),
    .s_stb_o  (s_stb_o),
    .s_dat_i  (s_dat_i),
    .s_ack_i  (s_ack_i),
    .s_err_i  (s_err_i),
    .s_rty_i  (s_rty_i),
    .grant_o  (grant_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk_i);
    #2;
  endtask

  task automatic clear_inputs;
    m_cyc_i  = '0;
    m_stb_i  = '0;
    m_we_i   = '0;
    m_lock_i = '0;
    m_addr_i = '0;
    m_dat_i  = '0;
    m_sel_i  = '0;
    s_dat_i  = '0;
    s_ack_i  = '0;
    s_err_i  = '0;
    s_rty_i  = '0;
  endtask

  initial begin
    int cnt;
    logic [1:0] exp_g;

    // Reset holds everything low even with a request pending
    clear_inputs();
    rst_i    = 1'b0;
    m_cyc_i  = 2'b01;
    m_stb_i  = 2'b01;
    m_addr_i = 64'h0000_0104;
    s_ack_i  = 2'b10;
    tick();
    tick();
    check_val("rst_grant", grant_o, 2'b00);
    check_val("rst_s_stb", s_stb_o, 2'b00);
    check_val("rst_s_cyc", s_cyc_o, 2'b00);
    check_val("rst_m_ack", m_ack_o, 2'b00);
    check_val("rst_m_dat", m_dat_o, 32'h0);
    check_val("rst_s_addr", s_addr_o, 32'h0);
    clear_inputs();
    rst_i = 1'b1;
    tick();
    check_val("idle_grant", grant_o, 2'b00);

    // Single master read from the counter
    m_cyc_i  = 2'b01;
    m_stb_i  = 2'b01;
    m_addr_i = 64'h0000_0104;
    m_sel_i  = 8'h0F;
    #1;
    check_val("req_no_grant_yet", grant_o, 2'b00);
    tick();
    check_val("t1_grant", grant_o, 2'b01);
    check_val("t1_s_stb", s_stb_o, 2'b10);
    check_val("t1_s_cyc", s_cyc_o, 2'b10);
    check_val("t1_s_addr", s_addr_o, 32'h0000_0104);
    check_val("t1_s_sel", s_sel_o, 4'hF);
    s_ack_i = 2'b10;
    s_dat_i = {32'hDEAD_BEEF, 32'h1234_5678};
    #1;
    check_val("t1_m_ack", m_ack_o, 2'b01);
    check_val("t1_m_dat", m_dat_o, 32'hDEAD_BEEF);
    m_cyc_i = 2'b00;
    m_stb_i = 2'b00;
    #1;
    check_val("drop_s_stb", s_stb_o, 2'b00);
    check_val("late_ack_masked", m_ack_o, 2'b00);
    tick();
    check_val("t1_back_idle", grant_o, 2'b00);
    clear_inputs();

    // Contention: round robin alternates starting with m1
    for (int i = 0; i < 4; i++) begin
      m_cyc_i = 2'b11;
      tick();
      exp_g = (i % 2 == 0) ? 2'b10 : 2'b01;
      check_val("rr_grant", grant_o, exp_g);
      m_cyc_i = 2'b00;
      tick();
      check_val("rr_idle_gap", grant_o, 2'b00);
    end

    // Lock keeps m0 owner while m1 waits
    m_cyc_i  = 2'b01;
    m_lock_i = 2'b01;
    tick();
    check_val("lock_grant", grant_o, 2'b01);
    m_cyc_i = 2'b10;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("lock_hold", grant_o, 2'b01);
    end
    m_lock_i = 2'b00;
    tick();
    check_val("lock_release_idle", grant_o, 2'b00);
    tick();
    check_val("lock_m1_grant", grant_o, 2'b10);
    m_cyc_i = 2'b00;
    tick();
    clear_inputs();

    // Unmapped write by m1
    m_cyc_i  = 2'b10;
    m_stb_i  = 2'b10;
    m_we_i   = 2'b10;
    m_addr_i = 64'h0000_0400_0000_0000;
    tick();
    check_val("um_grant", grant_o, 2'b10);
    check_val("um_s_stb", s_stb_o, 2'b00);
    check_val("um_err_first", m_err_o, 2'b00);
    tick();
    check_val("um_err_pulse", m_err_o, 2'b10);
    tick();
    check_val("um_err_once", m_err_o, 2'b00);
    clear_inputs();
    tick();

    // Timeout on a UART access that is never acknowledged
    m_cyc_i  = 2'b01;
    m_stb_i  = 2'b01;
    m_addr_i = 64'h0000_0010;
    tick();
    check_val("to_s_stb", s_stb_o, 2'b01);
    cnt = 0;
    while (m_err_o[0] !== 1'b1 && cnt < 400) begin
      tick();
      cnt++;
    end
    check_val("to_cycles", cnt, 255);
    check_val("to_stb_off", s_stb_o, 2'b00);
    tick();
    check_val("to_err_once", m_err_o, 2'b00);
    check_val("to_stb_still_off", s_stb_o, 2'b00);
    m_stb_i = 2'b00;
    tick();
    m_stb_i = 2'b01;
    #1;
    check_val("to_stb_rearm", s_stb_o, 2'b01);

    // Slave ERR wins over ACK
    m_addr_i = 64'h0000_0104;
    s_ack_i  = 2'b10;
    s_err_i  = 2'b10;
    #1;
    check_val("errack_ack", m_ack_o, 2'b00);
    check_val("errack_err", m_err_o, 2'b01);
    clear_inputs();
    tick();

    // Async reset during a granted write
    m_cyc_i  = 2'b01;
    m_stb_i  = 2'b01;
    m_we_i   = 2'b01;
    m_addr_i = 64'h0000_0104;
    m_dat_i  = 64'h0000_0000_CAFE_F00D;
    tick();
    check_val("wr_s_we", s_we_o, 1'b1);
    check_val("wr_s_dat", s_dat_o, 32'hCAFE_F00D);
    s_ack_i = 2'b10;
    rst_i   = 1'b0;
    #1;
    check_val("arst_grant", grant_o, 2'b00);
    check_val("arst_s_stb", s_stb_o, 2'b00);
    check_val("arst_s_we", s_we_o, 1'b0);
    check_val("arst_s_dat", s_dat_o, 32'h0);
    check_val("arst_m_ack", m_ack_o, 2'b00);
    clear_inputs();
    tick();
    rst_i = 1'b1;
    tick();
    check_val("post_rst_idle", grant_o, 2'b00);
    m_cyc_i = 2'b11;
    tick();
    check_val("post_rst_m1_first", grant_o, 2'b10);
    clear_inputs();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
